// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus master: FSM encoding and register map.
// Register offsets are relative to the master's BASE_ADDR window.
package periph_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    IRQ_RD = 3'd3,
    IRQ_WR = 3'd4
  } state_t;

  localparam logic [31:0] OFF_TH     = 32'h00;
  localparam logic [31:0] OFF_TL     = 32'h04;
  localparam logic [31:0] OFF_TCON   = 32'h08;
  localparam logic [31:0] OFF_LED    = 32'h0C;
  localparam logic [31:0] OFF_SWITCH = 32'h10;
  localparam logic [31:0] OFF_DIGI   = 32'h14;

  // Timer interrupt flag lives in TCON bit 2.
  localparam logic [31:0] TCON_IRQ_MASK = 32'h0000_0004;

endpackage

// File: rtl/periph_master.sv
// Host command -> peripheral bus master with timer-interrupt bookkeeping (PERIPH_MASTER_IRQ_ACK_EN adds TCON ack).
// Latency: cmd accept to rsp_valid 2 cycles for legal addresses, 1 cycle for illegal ones.
// Backpressure: one command in flight; cmd_ready low until the response is taken and no irq is pending.
module periph_master
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter logic [31:0] LAST_OFFSET = 32'h0000_0014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        irqin,
  output logic [15:0] irq_count
);

  state_t state;
  logic   irq_pend;
  logic   addr_ok;
  logic   accept;
  logic   pend_clr;
  logic   pend_nxt;
  logic   irq_new;

  // A new interrupt that lands on the same edge as the clear is a fresh set and counts.
  always_comb begin
    addr_ok  = (cmd_addr[1:0] == 2'b00) && (cmd_addr >= BASE_ADDR) &&
               ((cmd_addr - BASE_ADDR) <= LAST_OFFSET);
    accept   = cmd_valid && cmd_ready;
    pend_clr = (state == IDLE) && irq_pend && !accept;
    pend_nxt = irqin || (irq_pend && !pend_clr);
    irq_new  = irqin && (!irq_pend || pend_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= 32'h0;
      wdata     <= 32'h0;
      irq_pend  <= 1'b0;
      irq_count <= 16'h0;
    end else begin
      rd        <= 1'b0;
      wr        <= 1'b0;
      cmd_ready <= 1'b0;
      irq_pend  <= pend_nxt;
      if (irq_new) irq_count <= irq_count + 16'd1;

      case (state)
        IDLE: begin
          if (accept) begin
            if (addr_ok) begin
              state <= ACCESS;
              addr  <= cmd_addr;
              rd    <= !cmd_wr;
              wr    <= cmd_wr;
              if (cmd_wr) wdata <= cmd_wdata;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
`ifdef PERIPH_MASTER_IRQ_ACK_EN
          else if (irq_pend) begin
            state <= IRQ_RD;
            rd    <= 1'b1;
            addr  <= BASE_ADDR + OFF_TCON;
          end
`endif
          else begin
            cmd_ready <= !pend_nxt;
          end
        end

        ACCESS: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= wr ? 32'h0 : rdata;
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= !pend_nxt;
          end
        end

`ifdef PERIPH_MASTER_IRQ_ACK_EN
        // The TCON value read here is captured straight into wdata with the flag cleared.
        IRQ_RD: begin
          state <= IRQ_WR;
          wr    <= 1'b1;
          wdata <= rdata & ~TCON_IRQ_MASK;
        end

        IRQ_WR: begin
          state     <= IDLE;
          cmd_ready <= !pend_nxt;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_master.sv
// Randomized self-checking bench for periph_master against a host-level register model.
module tb_periph_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] LAST = 32'h0000_0014;
`ifdef PERIPH_MASTER_IRQ_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irqin;
  logic [15:0] irq_count;

  periph_master #(.BASE_ADDR(BASE), .LAST_OFFSET(LAST)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .irqin(irqin), .irq_count(irq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_irq = 0;
  logic [31:0] ref_regs [8];

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0: return 32'h0000_0012;
      1: return 32'h0000_0034;
      2: return 32'h0000_0007;
      4: return 32'h0000_00A5;
      5: return 32'h0000_005A;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) <= LAST);
  endfunction

  function automatic logic [2:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[4:2];
  endfunction

  // Peripheral: register file with combinational read data, garbage when not strobed.
  logic [31:0] periph_mem [8];
  assign rdata = (rd && legal(addr)) ? periph_mem[widx(addr)] : 32'hDEAD_BEEF;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) periph_mem[i] <= init_val(i);
    end else if (wr && legal(addr)) begin
      periph_mem[widx(addr)] <= wdata;
    end
  end

  // Bus monitor.
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0, last_ra = 32'h0;
  always @(posedge clk) begin
    if (rd) begin rd_cnt <= rd_cnt + 1; last_ra <= addr; end
    if (wr) begin wr_cnt <= wr_cnt + 1; last_wa <= addr; last_wd <= wdata; end
    if (rd && wr) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 8; i++) ref_regs[i] = init_val(i);
    exp_irq = 0;
  endtask

  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input int xrd, input int xwr);
    logic leg;
    logic [31:0] exp_d;
    int n, lat, rd0, wr0;
    leg   = legal(a);
    exp_d = (leg && !w) ? ref_regs[widx(a)] : 32'h0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n >= 50), 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("rsp_latency", lat, leg ? 2 : 1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, exp_d);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'h0);
      @(negedge clk);
    end
    chk("rsp_err", 32'(rsp_err), leg ? 32'h0 : 32'h1);
    chk("rsp_rdata", rsp_rdata, exp_d);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'h0);
    chk("rd_pulses", rd_cnt - rd0, xrd + int'(leg && !w));
    chk("wr_pulses", wr_cnt - wr0, xwr + int'(leg && w));
    if (leg && w) begin
      chk("wr_addr", last_wa, a);
      chk("wr_data", last_wd, d);
      ref_regs[widx(a)] = d;
    end
  endtask

  task automatic irq_pulse();
    irqin = 1'b1;
    @(negedge clk);
    irqin = 1'b0;
    exp_irq++;
    if (ACK != 0) ref_regs[2] = ref_regs[2] & ~32'h4;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 30) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(n >= 30), 32'h0);
  endtask

  task automatic irq_directed();
    logic [31:0] t, wa0, wd0, ra0;
    int rd0, wr0;
    t = ref_regs[2]; wa0 = last_wa; wd0 = last_wd; ra0 = last_ra;
    rd0 = rd_cnt; wr0 = wr_cnt;
    irq_pulse();
    chk("irq_blocks_cmd", 32'(cmd_ready), 32'h0);
    wait_idle();
    chk("irq_count", 32'(irq_count), 32'(exp_irq));
    chk("irq_rd_pulses", rd_cnt - rd0, ACK);
    chk("irq_wr_pulses", wr_cnt - wr0, ACK);
    chk("irq_rd_addr", last_ra, (ACK != 0) ? BASE + 32'h8 : ra0);
    chk("irq_wr_addr", last_wa, (ACK != 0) ? BASE + 32'h8 : wa0);
    chk("irq_wr_data", last_wd, (ACK != 0) ? (t & ~32'h4) : wd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, 32'(rd), 32'h0);
    chk({tag, "_wr"}, 32'(wr), 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    chk({tag, "_irq_count"}, 32'(irq_count), 32'h0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sel, vld_seen;
    logic [31:0] a;
    reset = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; irqin = 1'b0;
    reset_ref();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'h1);

    // Directed register accesses and illegal addresses.
    do_cmd(1'b0, 32'h4000_0010, 32'h0, 0, 0, 0);
    do_cmd(1'b1, 32'h4000_000C, 32'h3C, 0, 0, 0);
    do_cmd(1'b0, 32'h4000_000C, 32'h0, 1, 0, 0);
    do_cmd(1'b0, 32'h4000_0018, 32'h0, 0, 0, 0);
    do_cmd(1'b0, 32'h4000_0002, 32'h0, 0, 0, 0);
    do_cmd(1'b0, 32'h4000_0004, 32'h0, 5, 0, 0);

    // Interrupt alone, then a command arriving while the interrupt is pending.
    irq_directed();
    irq_pulse();
    do_cmd(1'b0, 32'h4000_0008, 32'h0, 0, ACK, ACK);
    chk("irq_count_overlap", 32'(irq_count), 32'(exp_irq));

    // irqin held high across several cycles during a response counts once.
    fork
      do_cmd(1'b0, 32'h4000_0000, 32'h0, 6, 0, 0);
      begin
        repeat (2) @(negedge clk);
        irqin = 1'b1;
        repeat (3) @(negedge clk);
        irqin = 1'b0;
      end
    join
    exp_irq++;
    if (ACK != 0) ref_regs[2] = ref_regs[2] & ~32'h4;
    wait_idle();
    chk("irq_count_held", 32'(irq_count), 32'(exp_irq));

    // Randomized traffic with occasional interrupts ahead of a command.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = BASE + 32'(sel * 4);
      else if (sel == 6) a = BASE + 32'h18;
      else if (sel == 7) a = BASE + 32'($urandom_range(0, 5) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = BASE - 32'h4;
      else               a = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        irq_pulse();
        do_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 4), ACK, ACK);
        chk("irq_count_rand", 32'(irq_count), 32'(exp_irq));
      end else begin
        do_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 4), 0, 0);
      end
    end

    // Reset during the access cycle abandons the command.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h4000_0010;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_reset_rd", 32'(rd), 32'h1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    reset_ref();
    @(negedge clk);
    chk("ready_after_rerelease", 32'(cmd_ready), 32'h1);
    vld_seen = 0;
    repeat (5) begin
      if (rsp_valid) vld_seen++;
      @(negedge clk);
    end
    chk("no_rsp_after_reset", vld_seen, 0);
    do_cmd(1'b0, 32'h4000_0010, 32'h0, 0, 0, 0);

    chk("rd_wr_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/periph_master.md
PERIPH_MASTER -- requirements
Module: periph_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h40000000, base of the peripheral register window.
REQ-002 Parameter LAST_OFFSET, default 32'h14, byte offset of the highest legal register.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-low reset (reset==0 resets immediately).
REQ-005 Port cmd_valid  input  1  host command request.
REQ-006 Port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-007 Port cmd_wr  input  1  1 = write, 0 = read.
REQ-008 Port cmd_addr  input  32  byte address.
REQ-009 Port cmd_wdata  input  32  write data.
REQ-010 Port rsp_valid  output  1  response available; held until rsp_ready.
REQ-011 Port rsp_ready  input  1  host consumes response.
REQ-012 Port rsp_rdata  output  32  read data (0 for writes and errors).
REQ-013 Port rsp_err  output  1  address illegal; no bus access made.
REQ-014 Ports rd, wr  output  1 each  peripheral bus strobes, registered.
REQ-015 Ports addr, wdata  output  32 each  peripheral bus address/data, registered.
REQ-016 Port rdata  input  32  peripheral read data, combinational from rd/addr.
REQ-017 Port irqin  input  1  peripheral timer interrupt (TCON bit 2).
REQ-018 Port irq_count  output  16  number of interrupts taken, wraps at 16'hFFFF->0.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP, IRQ_RD, IRQ_WR.
REQ-020 IDLE: cmd_ready=1 unless irq_pend=1; accepted command with legal address -> ACCESS, illegal -> RESP with rsp_err=1.
REQ-021 Legal address: BASE_ADDR <= cmd_addr <= BASE_ADDR+LAST_OFFSET and cmd_addr[1:0]==0.
REQ-022 ACCESS lasts exactly one cycle with addr/wdata driven and exactly one of rd/wr =1; read samples rdata into rsp_rdata at end of that cycle; -> RESP.
REQ-023 RESP: rsp_valid=1 until rsp_ready sampled 1, then -> IDLE; latency cmd accept to rsp_valid = 2 cycles (legal) or 1 cycle (illegal).
REQ-024 rd and wr SHALL never be 1 in the same cycle and SHALL be 0 outside ACCESS/IRQ_RD/IRQ_WR; addr/wdata hold last value when idle.
REQ-025 irq_pend SET when irqin==1 at posedge (any state); cleared on entry to the IRQ sequence; irq_count increments once per set of irq_pend from 0.
REQ-026 IRQ has priority over a same-cycle cmd_valid in IDLE; an in-progress command/response always completes first.
REQ-027 irqin held high across multiple cycles while irq_pend already set SHALL count once.

Reset
REQ-028 On reset==0: state IDLE, rd=wr=0, addr=wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, irq_pend=0, irq_count=0, cmd_ready=0; reset mid-access abandons it with no response.
REQ-029 cmd_ready SHALL become 1 the first cycle after reset release.

Configuration
REQ-030 Macro PERIPH_MASTER_IRQ_ACK_EN defined: IDLE with irq_pend -> IRQ_RD (rd=1, addr=BASE_ADDR+8, capture rdata) -> IRQ_WR (wr=1, addr=BASE_ADDR+8, wdata=captured & ~32'h4) -> IDLE.
REQ-031 Macro undefined: irq_pend clears in IDLE in one cycle with no bus traffic; irq_count still increments; IRQ_RD/IRQ_WR unreachable.

Structure
REQ-032 Shared package periph_pkg SHALL hold FSM state encoding and register offsets (TH 0x0, TL 0x4, TCON 0x8, LED 0xC, SWITCH 0x10, DIGI 0x14).
REQ-033 Single module; no sub-module.

Verification
REQ-034 Read cmd_addr=32'h40000010, rdata model 32'h000000A5 -> one rd pulse, rsp_valid 2 cycles later, rsp_rdata=32'hA5, rsp_err=0.
REQ-035 Write 32'h4000000C data 32'h3C -> one wr pulse with addr/wdata matching, rsp_valid, rsp_rdata=0.
REQ-036 Read 32'h40000018 and 32'h40000002 -> no rd/wr, rsp_err=1 after 1 cycle.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout.
REQ-038 With PERIPH_MASTER_IRQ_ACK_EN, irqin pulse while TCON=3'b111 -> read of 0x40000008 then write 32'h3; irq_count=1; a simultaneous cmd waits until sequence ends.
REQ-039 reset asserted during ACCESS -> all outputs at reset values within the same cycle, no rsp_valid after release.
